ffsr_spike_binary_array: RTL

Multi-channel, parametrised successor to the single-channel 3-bit FFSR spike-binary counter. It holds CHANNELS independent WIDTH-bit up/down counters, each driven by per-channel inc/dec spike strobes, with saturate-or-wrap mode and a sticky overflow flag. A readout engine serialises any one channel's value as a binary-weighted spike train, MSB first, for the downstream spike-domain encoder stage in the FFSR datapath.

---
 rtl/ffsr_spike_binary_array_pkg.sv | 12 +
 rtl/ffsr_chan_counter.sv | 42 ++++
 rtl/ffsr_spike_binary_array.sv | 118 +++++++++++
 3 files changed

// File: rtl/ffsr_spike_binary_array_pkg.sv
// Shared types for the FFSR spike-binary counter array: readout states and counter mode constants.
package ffsr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rd_state_e;

  localparam bit MODE_SAT  = 1'b1;
  localparam bit MODE_WRAP = 1'b0;

endpackage

// File: rtl/ffsr_chan_counter.sv
// One up/down spike counter with saturate-or-wrap behaviour and a sticky over/underflow flag.
module ffsr_chan_counter
  import ffsr_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter bit          SAT_EN = MODE_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  // clr wins; simultaneous inc and dec cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == '1) begin
        ovf <= 1'b1;
        if (SAT_EN == MODE_WRAP) count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (count == '0) begin
        ovf <= 1'b1;
        if (SAT_EN == MODE_WRAP) count <= '1;
      end else begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ffsr_spike_binary_array.sv
// Array of spike counters plus a readout engine that serialises one channel MSB-first as a spike train.
module ffsr_spike_binary_array
  import ffsr_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 3,
  parameter bit          SAT_EN   = MODE_SAT,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       ovf,
  input  logic                      rd_start,
  input  logic [CH_W-1:0]           rd_ch,
  output logic                      rd_busy,
  output logic                      spike_out,
  output logic                      spike_valid,
  output logic                      rd_done
);

  localparam int unsigned IDX_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] cnt [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    ffsr_chan_counter #(
      .WIDTH  (WIDTH),
      .SAT_EN (SAT_EN)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[c]),
      .dec   (dec[c]),
      .clr   (clr[c]),
      .count (cnt[c]),
      .ovf   (ovf[c])
    );
    assign count_out[c*WIDTH +: WIDTH] = cnt[c];
  end

  rd_state_e        state, state_n;
  logic [WIDTH-1:0] snap, snap_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             busy_n, spike_n, valid_n, done_n;
  logic [WIDTH-1:0] sel_val, snap_sh;
  logic             sel_ok;

  // Mux the registered (pre-update) value of the requested channel
  always_comb begin
    sel_val = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (rd_ch == CH_W'(c)) sel_val = cnt[c];
    end
    sel_ok = (32'(rd_ch) < CHANNELS);
  end

  always_comb begin
    state_n = state;
    snap_n  = snap;
    idx_n   = idx;
    busy_n  = 1'b0;
    spike_n = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    snap_sh = '0;
    case (state)
      IDLE: begin
        if (rd_start && sel_ok) begin
          state_n = SHIFT;
          snap_n  = sel_val;
          idx_n   = IDX_W'(WIDTH - 1);
          busy_n  = 1'b1;
          valid_n = 1'b1;
          spike_n = sel_val[WIDTH-1];
        end
      end
      SHIFT: begin
        // idx names the bit currently on spike_out; rd_start is ignored here
        if (idx == '0) begin
          state_n = IDLE;
        end else begin
          idx_n   = idx - IDX_W'(1);
          snap_sh = snap >> idx_n;
          busy_n  = 1'b1;
          valid_n = 1'b1;
          spike_n = snap_sh[0];
          done_n  = (idx_n == '0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '0;
      idx         <= '0;
      rd_busy     <= 1'b0;
      spike_out   <= 1'b0;
      spike_valid <= 1'b0;
      rd_done     <= 1'b0;
    end else begin
      state       <= state_n;
      snap        <= snap_n;
      idx         <= idx_n;
      rd_busy     <= busy_n;
      spike_out   <= spike_n;
      spike_valid <= valid_n;
      rd_done     <= done_n;
    end
  end

endmodule
